// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch, MM:SS.CC in packed BCD.
//
// The 10 ms divided clock is sampled as ordinary data in the clk domain; each
// observed 0->1 transition becomes a one-cycle count enable (tick).
//
// Parameters:
//   WRAP       1: roll 59:59.99 -> 00:00.00 and keep running; 0: saturate and go FULL
//   MAX_MIN_T  largest tens-of-minutes digit (limit is MAX_MIN_T:9 minutes)
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   slow_clk    10 ms divided clock, sampled as data
//   start_stop  debounced single-cycle pulse: start / pause / resume
//   clear       debounced single-cycle pulse: back to IDLE, count to zero
//   bcd         {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4 bits each
//   running     state is RUN
//   full        state is FULL (only when WRAP = 0)
//   wrap_pulse  one-cycle pulse on rollover (only when WRAP = 1)
module stopwatch_bcd #(
  parameter bit          WRAP      = 1'b0,
  parameter int unsigned MAX_MIN_T = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slow_clk,
  input  logic        start_stop,
  input  logic        clear,
  output logic [23:0] bcd,
  output logic        running,
  output logic        full,
  output logic        wrap_pulse
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StFull} state_e;

  // Digit index 0 = cs_o ... 5 = min_t, so the packed array is the bcd word.
  localparam logic [3:0] MinTMax = 4'(MAX_MIN_T);
  localparam logic [5:0][3:0] DigTerm = {MinTMax, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  // Per-digit rollover value; min_t never rolls because terminal is caught first.
  localparam logic [5:0][3:0] DigRoll = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  state_e          state_q, state_d;
  logic [5:0][3:0] dig_q, dig_d, dig_inc;
  logic            prev_slow_q;
  logic            wrap_pulse_q, wrap_pulse_d;
  logic            tick;
  logic            terminal;
  logic            carry;

  assign tick     = slow_clk & ~prev_slow_q;
  assign terminal = (dig_q == DigTerm);

  // BCD ripple increment, one digit at a time.
  always_comb begin
    dig_inc = dig_q;
    carry   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (dig_q[i] == DigRoll[i]) begin
          dig_inc[i] = 4'd0;
        end else begin
          dig_inc[i] = dig_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    dig_d        = dig_q;
    wrap_pulse_d = 1'b0;
    if (clear) begin
      state_d = StIdle;
      dig_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          dig_d = '0;
          if (start_stop) state_d = StRun;
        end
        StRun: begin
          if (tick && terminal && !WRAP) begin
            // Saturating terminal tick outranks a simultaneous start_stop.
            state_d = StFull;
          end else begin
            if (tick) begin
              if (terminal) begin
                dig_d        = '0;
                wrap_pulse_d = 1'b1;
              end else begin
                dig_d = dig_inc;
              end
            end
            if (start_stop) state_d = StPause;
          end
        end
        StPause: begin
          if (start_stop) state_d = StRun;
        end
        StFull: begin
          state_d = StFull;
        end
        default: begin
          state_d = StIdle;
          dig_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dig_q        <= '0;
      // Held high so a slow_clk already high at release produces no tick.
      prev_slow_q  <= 1'b1;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dig_q        <= dig_d;
      prev_slow_q  <= slow_clk;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign bcd        = dig_q;
  assign running    = (state_q == StRun);
  assign full       = (state_q == StFull);
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: one saturating (WRAP = 0) and one wrapping
// (WRAP = 1) instance share all inputs. The near-terminal value is preloaded by
// force/release on the digit register so the terminal cases stay short.
module tb_stopwatch_bcd;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        slow_clk   = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear      = 1'b0;

  logic [23:0] bcd_s, bcd_w;
  logic        run_s, run_w, full_s, full_w, wp_s, wp_w;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  stopwatch_bcd #(
    .WRAP      (1'b0),
    .MAX_MIN_T (5)
  ) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .start_stop (start_stop),
    .clear      (clear),
    .bcd        (bcd_s),
    .running    (run_s),
    .full       (full_s),
    .wrap_pulse (wp_s)
  );

  stopwatch_bcd #(
    .WRAP      (1'b1),
    .MAX_MIN_T (5)
  ) u_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .start_stop (start_stop),
    .clear      (clear),
    .bcd        (bcd_w),
    .running    (run_w),
    .full       (full_w),
    .wrap_pulse (wp_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus changes on negedge; outputs are checked on negedge too.
  task automatic tick();
    @(negedge clk) slow_clk = 1'b1;
    @(negedge clk) slow_clk = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_ss();
    @(negedge clk) start_stop = 1'b1;
    @(negedge clk) start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with slow_clk high
    idle(3);
    check_eq("rst_bcd_s", 32'(bcd_s), 'h0);
    check_eq("rst_bcd_w", 32'(bcd_w), 'h0);
    check_eq("rst_run", 32'(run_s), 0);
    check_eq("rst_full", 32'(full_s), 0);
    check_eq("rst_wp", 32'(wp_w), 0);
    @(negedge clk) rst_n = 1'b1;
    pulse_ss();
    idle(3);
    check_eq("no_tick_at_release", 32'(bcd_s), 'h0);
    check_eq("run_after_start", 32'(run_s), 1);
    @(negedge clk) slow_clk = 1'b0;
    tick_n(3);
    check_eq("three_ticks_s", 32'(bcd_s), 'h000003);
    check_eq("three_ticks_w", 32'(bcd_w), 'h000003);
    check_eq("three_ticks_run", 32'(run_s), 1);

    // Carry chain
    pulse_clr();
    check_eq("clr_bcd", 32'(bcd_s), 'h0);
    check_eq("clr_run", 32'(run_s), 0);
    pulse_ss();
    tick_n(100);
    check_eq("one_second", 32'(bcd_s), 'h000100);
    tick_n(5900);
    check_eq("one_minute_s", 32'(bcd_s), 'h010000);
    check_eq("one_minute_w", 32'(bcd_w), 'h010000);

    // tick + start_stop in RUN: increment then pause
    @(negedge clk) begin slow_clk = 1'b1; start_stop = 1'b1; end
    @(negedge clk) begin slow_clk = 1'b0; start_stop = 1'b0; end
    check_eq("pause_inc", 32'(bcd_s), 'h010001);
    check_eq("pause_run", 32'(run_s), 0);
    tick_n(2);
    check_eq("pause_hold", 32'(bcd_s), 'h010001);
    pulse_ss();
    check_eq("resume_run", 32'(run_s), 1);
    tick();
    check_eq("resume_count", 32'(bcd_s), 'h010002);

    // clear + tick in RUN: clear wins
    pulse_clr();
    pulse_ss();
    tick_n(42);
    check_eq("at_42", 32'(bcd_s), 'h000042);
    @(negedge clk) begin slow_clk = 1'b1; clear = 1'b1; end
    @(negedge clk) begin slow_clk = 1'b0; clear = 1'b0; end
    check_eq("clr_tick_bcd", 32'(bcd_s), 'h0);
    check_eq("clr_tick_run", 32'(run_s), 0);
    tick();
    check_eq("idle_no_count", 32'(bcd_s), 'h0);

    // Terminal value: saturate vs wrap
    pulse_ss();
    @(negedge clk);
    force u_sat.dig_q  = 24'h595998;
    force u_wrap.dig_q = 24'h595998;
    #1;
    release u_sat.dig_q;
    release u_wrap.dig_q;
    tick();
    check_eq("term_s", 32'(bcd_s), 'h595999);
    check_eq("term_w", 32'(bcd_w), 'h595999);
    check_eq("term_full_pre", 32'(full_s), 0);
    tick();
    check_eq("sat_bcd", 32'(bcd_s), 'h595999);
    check_eq("sat_full", 32'(full_s), 1);
    check_eq("sat_run", 32'(run_s), 0);
    check_eq("sat_wp", 32'(wp_s), 0);
    check_eq("wrap_bcd", 32'(bcd_w), 'h0);
    check_eq("wrap_wp", 32'(wp_w), 1);
    check_eq("wrap_run", 32'(run_w), 1);
    check_eq("wrap_full", 32'(full_w), 0);
    @(negedge clk);
    check_eq("wrap_wp_one_cycle", 32'(wp_w), 0);
    tick();
    check_eq("sat_hold", 32'(bcd_s), 'h595999);
    check_eq("wrap_count_on", 32'(bcd_w), 'h000001);
    pulse_ss();
    check_eq("full_ignores_ss", 32'(full_s), 1);
    check_eq("full_ignores_ss_run", 32'(run_s), 0);
    pulse_clr();
    check_eq("full_clr_bcd", 32'(bcd_s), 'h0);
    check_eq("full_clr_full", 32'(full_s), 0);

    // Mid-run reset
    pulse_ss();
    tick_n(5);
    check_eq("pre_rst_w", 32'(bcd_w), 'h000005);
    check_eq("pre_rst_s", 32'(bcd_s), 'h000005);
    @(negedge clk) begin rst_n = 1'b0; slow_clk = 1'b1; end
    @(negedge clk) rst_n = 1'b1;
    check_eq("mid_rst_bcd", 32'(bcd_w), 'h0);
    check_eq("mid_rst_run", 32'(run_w), 0);
    check_eq("mid_rst_wp", 32'(wp_w), 0);
    pulse_ss();
    idle(2);
    check_eq("post_rst_no_tick", 32'(bcd_w), 'h0);
    check_eq("post_rst_run", 32'(run_w), 1);
    @(negedge clk) slow_clk = 1'b0;
    tick();
    check_eq("post_rst_fresh_edge", 32'(bcd_w), 'h000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
